// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: hunts for the COM symbol, locks byte alignment after
// ALIGN_COUNT aligned COMs, then strobes out every non-COM byte on its boundary.
module serial_paralelo #(
    parameter logic [7:0]  COM         = 8'hBC,
    parameter int unsigned ALIGN_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    localparam logic [3:0] ALIGN_TARGET = 4'(ALIGN_COUNT);

    function automatic logic is_com(input logic [7:0] b);
        return (b == COM);
    endfunction

    logic [1:0] state_r;
    logic [7:0] sr_r;
    logic [2:0] bit_cnt_r;
    logic [3:0] com_cnt_r;
    logic [7:0] data_out_r;
    logic       valid_r;
    logic       active_r;

    logic [1:0] state_s;
    logic [7:0] byte_s;
    logic       boundary_s;
    logic       com_s;
    logic [2:0] bit_cnt_s;
    logic [3:0] com_cnt_s;
    logic [7:0] data_out_s;
    logic       valid_s;
    logic       active_s;

    // Candidate byte includes the bit being sampled at this edge.
    assign byte_s     = {sr_r[6:0], data_in};
    assign boundary_s = (bit_cnt_r == 3'd7);
    assign com_s      = is_com(byte_s);

    // Next-state logic for alignment FSM and output registers.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r + 3'd1;
        com_cnt_s  = com_cnt_r;
        data_out_s = data_out_r;
        valid_s    = 1'b0;
        active_s   = active_r;

        case (state_r)
            SEARCH: begin
                // Hunting ignores bit_cnt; a hit restarts the byte phase at zero.
                bit_cnt_s = 3'd0;
                if (com_s) begin
                    com_cnt_s = 4'd1;
                    if (ALIGN_TARGET == 4'd1) begin
                        state_s  = ACTIVE;
                        active_s = 1'b1;
                    end else begin
                        state_s = ALIGN;
                    end
                end else begin
                    com_cnt_s = 4'd0;
                end
            end
            ALIGN: begin
                if (boundary_s) begin
                    if (com_s) begin
                        com_cnt_s = com_cnt_r + 4'd1;
                        if (com_cnt_s == ALIGN_TARGET) begin
                            state_s  = ACTIVE;
                            active_s = 1'b1;
                        end else begin
                            state_s = ALIGN;
                        end
                    end else begin
                        state_s   = SEARCH;
                        com_cnt_s = 4'd0;
                        bit_cnt_s = 3'd0;
                    end
                end else begin
                    state_s = ALIGN;
                end
            end
            ACTIVE: begin
                active_s = 1'b1;
                if (boundary_s && !com_s) begin
                    data_out_s = byte_s;
                    valid_s    = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            default: begin
                state_s   = SEARCH;
                bit_cnt_s = 3'd0;
                com_cnt_s = 4'd0;
                active_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_r    <= SEARCH;
            sr_r       <= 8'h00;
            bit_cnt_r  <= 3'd0;
            com_cnt_r  <= 4'd0;
            data_out_r <= 8'h00;
            valid_r    <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            sr_r       <= byte_s;
            bit_cnt_r  <= bit_cnt_s;
            com_cnt_r  <= com_cnt_s;
            data_out_r <= data_out_s;
            valid_r    <= valid_s;
            active_r   <= active_s;
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign active    = active_r;

endmodule
